// File: rtl/adc_sclk_pkg.sv
// Shared types and constants for the ADC SCLK burst generator.
package adc_sclk_pkg;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  // SCLK level whenever no clock edges are being generated.
  localparam logic SCLK_IDLE = 1'b1;

endpackage

// File: rtl/adc_sclk_div.sv
// Loadable half-period down-counter. o_phase_end is high while the counter
// sits at zero, marking the last i_clk cycle of the current SCLK phase.
module adc_sclk_div
  import adc_sclk_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_phase_end
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;

  // Reload at each phase start, otherwise count down and hold at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= DIV_ZERO;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != DIV_ZERO) begin
      r_cnt <= r_cnt - DIV_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_phase_end = (r_cnt == DIV_ZERO);

endmodule

// File: rtl/adc_sclk_burst_gen.sv
// ADC SCLK burst generator: asserts the selected chip selects, produces a
// burst of N SCLK periods (each H i_clk cycles low then H high) and returns
// to idle with a one-cycle done pulse. SCLK leaves through a DDR output
// buffer, so both DDR levels are driven from registers.
// Optional feature: define ADC_SCLK_FULLRATE_EN to enable full-rate mode
// (i_half == 0 gives SCLK = ~i_clk for N cycles). Without it, i_half == 0
// behaves as a half-period of one cycle.
module adc_sclk_burst_gen
  import adc_sclk_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = 5,
  parameter int DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NCH-1:0]   i_ch_mask,
  input  logic [CNT_W-1:0] i_nbits,
  input  logic [DIV_W-1:0] i_half,
  output logic             o_busy,
  output logic             o_done,
  output logic [NCH-1:0]   o_cs_n,
  output logic             o_sclk_fall,
  output logic             o_adc_sclk_ddr_h,
  output logic             o_adc_sclk_ddr_l
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [NCH-1:0]   CS_IDLE  = {NCH{1'b1}};

  state_t           r_state;
  logic [CNT_W-1:0] r_nbits;
  logic [CNT_W-1:0] r_per_cnt;
  logic [DIV_W-1:0] r_half;
  logic [NCH-1:0]   r_cs_n;
  logic             r_busy;
  logic             r_done;
  logic             r_fall;
  logic             r_ddr_h;
  logic             r_ddr_l;
`ifdef ADC_SCLK_FULLRATE_EN
  logic             r_full;
`endif

  logic             w_phase_end;
  logic             w_div_load;
  logic [DIV_W-1:0] w_div_val;
  logic [DIV_W-1:0] w_half_eff;

`ifdef ADC_SCLK_FULLRATE_EN
  assign w_half_eff = i_half;
`else
  // Without full-rate support a zero half-period is the fastest divided rate.
  assign w_half_eff = (i_half == DIV_ZERO) ? DIV_ONE : i_half;
`endif

  // A new phase starts on entry to RUN and at each phase end inside RUN.
  assign w_div_load = (r_state == ST_LEAD) || ((r_state == ST_RUN) && w_phase_end);
  assign w_div_val  = r_half - DIV_ONE;

  adc_sclk_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_div_load),
    .i_load_val (w_div_val),
    .o_phase_end(w_phase_end)
  );

  // Burst sequencer with all outputs registered; r_ddr_h doubles as the
  // current SCLK level in divided mode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_nbits   <= CNT_ZERO;
      r_per_cnt <= CNT_ZERO;
      r_half    <= DIV_ZERO;
      r_cs_n    <= CS_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fall    <= 1'b0;
      r_ddr_h   <= SCLK_IDLE;
      r_ddr_l   <= SCLK_IDLE;
`ifdef ADC_SCLK_FULLRATE_EN
      r_full    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && (i_nbits != CNT_ZERO)) begin
            r_state <= ST_LEAD;
            r_nbits <= i_nbits;
            r_half  <= w_half_eff;
`ifdef ADC_SCLK_FULLRATE_EN
            r_full  <= (i_half == DIV_ZERO);
`endif
            r_cs_n  <= ~i_ch_mask;
            r_busy  <= 1'b1;
            r_ddr_h <= SCLK_IDLE;
            r_ddr_l <= SCLK_IDLE;
          end else if (i_start) begin
            // Zero-length request: acknowledge without touching CS or SCLK.
            r_done <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LEAD: begin
          r_state   <= ST_RUN;
          r_per_cnt <= CNT_ONE;
          r_fall    <= 1'b1;
`ifdef ADC_SCLK_FULLRATE_EN
          if (r_full) begin
            r_ddr_h <= 1'b0;
            r_ddr_l <= 1'b1;
          end else begin
            r_ddr_h <= ~SCLK_IDLE;
            r_ddr_l <= ~SCLK_IDLE;
          end
`else
          r_ddr_h <= ~SCLK_IDLE;
          r_ddr_l <= ~SCLK_IDLE;
`endif
        end
        ST_RUN: begin
`ifdef ADC_SCLK_FULLRATE_EN
          if (r_full) begin
            // One SCLK period per i_clk cycle.
            if (r_per_cnt == r_nbits) begin
              r_state <= ST_TAIL;
              r_ddr_h <= SCLK_IDLE;
              r_ddr_l <= SCLK_IDLE;
            end else begin
              r_per_cnt <= r_per_cnt + CNT_ONE;
              r_fall    <= 1'b1;
            end
          end else begin
`endif
          if (w_phase_end) begin
            if (r_ddr_h == ~SCLK_IDLE) begin
              r_ddr_h <= SCLK_IDLE;
              r_ddr_l <= SCLK_IDLE;
            end else if (r_per_cnt == r_nbits) begin
              r_state <= ST_TAIL;
            end else begin
              r_per_cnt <= r_per_cnt + CNT_ONE;
              r_ddr_h   <= ~SCLK_IDLE;
              r_ddr_l   <= ~SCLK_IDLE;
              r_fall    <= 1'b1;
            end
          end else begin
            r_state <= ST_RUN;
          end
`ifdef ADC_SCLK_FULLRATE_EN
          end
`endif
        end
        ST_TAIL: begin
          r_state   <= ST_IDLE;
          r_per_cnt <= CNT_ZERO;
          r_cs_n    <= CS_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_ddr_h   <= SCLK_IDLE;
          r_ddr_l   <= SCLK_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_per_cnt <= CNT_ZERO;
          r_cs_n    <= CS_IDLE;
          r_busy    <= 1'b0;
          r_ddr_h   <= SCLK_IDLE;
          r_ddr_l   <= SCLK_IDLE;
        end
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_cs_n           = r_cs_n;
  assign o_sclk_fall      = r_fall;
  assign o_adc_sclk_ddr_h = r_ddr_h;
  assign o_adc_sclk_ddr_l = r_ddr_l;

endmodule

// File: doc/adc_sclk_burst_gen.md
ADC_SCLK_BURST_GEN -- requirements
Module: adc_sclk_burst_gen

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of ADC chip-selects sharing one SCLK.
REQ-002 SHALL have parameter CNT_W, default 5, meaning the width of the burst-length field in SCLK periods.
REQ-003 SHALL have parameter DIV_W, default 4, meaning the width of the SCLK half-period field in i_clk cycles.
REQ-004 SHALL have port i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_start  in  1  single-cycle burst request.
REQ-007 SHALL have port i_ch_mask  in  NCH  channels to select for the burst.
REQ-008 SHALL have port i_nbits  in  CNT_W  number of SCLK periods in the burst.
REQ-009 SHALL have port i_half  in  DIV_W  SCLK half-period in i_clk cycles; 0 selects full-rate mode.
REQ-010 SHALL have port o_busy  out  1  high from LEAD through TAIL.
REQ-011 SHALL have port o_done  out  1  one-cycle burst completion pulse.
REQ-012 SHALL have port o_cs_n  out  NCH  active-low chip selects.
REQ-013 SHALL have port o_sclk_fall  out  1  strobe in the cycle SCLK is driven low; the driver shifts data on it.
REQ-014 SHALL have port o_adc_sclk_ddr_h / o_adc_sclk_ddr_l  out  1 each  DDR output-buffer levels for i_clk L->H / H->L.

Function
REQ-015 SHALL implement FSM IDLE -> LEAD -> RUN -> TAIL -> IDLE; all outputs registered.
REQ-016 In IDLE, i_start with i_nbits!=0 SHALL latch i_ch_mask, i_nbits and i_half and enter LEAD at the next edge.
REQ-017 i_start with i_nbits==0 SHALL produce o_done one cycle later, with no CS or SCLK activity.
REQ-018 i_start outside IDLE SHALL be ignored, and the latched values SHALL be stable for the whole burst.
REQ-019 In LEAD, which lasts one cycle, o_cs_n[i] SHALL be 0 for each masked channel and SCLK SHALL be high.
REQ-020 Divided mode (H=i_half>=1): RUN SHALL drive SCLK low for H cycles then high for H cycles, repeated N=i_nbits times, with ddr_h=ddr_l=SCLK level.
REQ-021 o_sclk_fall SHALL pulse exactly once per period, in the first low cycle.
REQ-022 After the final high phase, the FSM SHALL enter TAIL for one cycle with SCLK high and CS held.
REQ-023 At the next edge after TAIL, the FSM SHALL enter IDLE with o_cs_n all 1 and o_done=1 for one cycle.
REQ-024 o_busy SHALL be high for exactly 2+2*H*N cycles.
REQ-025 The period counter SHALL count up to N, compared at full CNT_W width, with no wrap; N=2^CNT_W-1 SHALL be legal.
REQ-026 The half-period counter SHALL be DIV_W wide and reload on every phase change.
REQ-027 Unmasked channels SHALL keep o_cs_n=1 throughout; a mask of all zeros SHALL still run the SCLK burst.

Reset
REQ-028 i_rst SHALL force IDLE, o_adc_sclk_ddr_h=o_adc_sclk_ddr_l=1, o_cs_n all 1, o_busy=0, o_done=0, o_sclk_fall=0, and counters to 0.
REQ-029 Reset mid-burst SHALL abort the burst without an o_done pulse; i_start in the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro ADC_SCLK_FULLRATE_EN defined: with i_half==0, RUN SHALL last N cycles with ddr_h=0 and ddr_l=1, so that SCLK = ~i_clk.
REQ-031 In full-rate mode, o_sclk_fall SHALL be high every RUN cycle, and o_busy SHALL last N+2 cycles.
REQ-032 Macro ADC_SCLK_FULLRATE_EN undefined: i_half==0 SHALL be treated as 1, and no full-rate logic SHALL be present.

Structure
REQ-033 Package adc_sclk_pkg SHALL hold the FSM state enum and the SCLK idle-level constant (1).
REQ-034 Sub-module adc_sclk_div SHALL hold the loadable half-period down-counter, with a phase-end strobe output.

Verification
REQ-035 Divided burst: N=14, H=2, mask=2'b01 -> 14 o_sclk_fall pulses; SCLK low/high 2 cycles each; o_cs_n=2'b10 for 58 cycles; o_done 1 cycle after busy falls; CS returns to 2'b11.
REQ-036 Full-rate burst (macro on): N=14, H=0 -> ddr_h=0 and ddr_l=1 for 14 cycles, busy for 16 cycles; with the macro off, the same stimulus behaves as H=1 (busy 30).
REQ-037 Zero length: N=0 -> o_done pulse 1 cycle after start, CS never asserted, SCLK stays 1.
REQ-038 Start while busy: i_start in RUN with different parameters -> the current burst completes unchanged and no second burst follows.
REQ-039 Reset mid-burst: i_rst in the 10th RUN cycle -> next cycle SCLK=1, CS all 1, busy=0, no o_done.
REQ-040 Max length: N=31, H=15, mask=2'b11 -> 31 falls, busy 932 cycles, both CS low throughout the burst.
